// File: rtl/shared_resource_access_ctrl_if.sv
// Handshake bundle between requester agents and the shared-resource access controller.
// The master modport faces the requesters; the slave modport faces the controller.
interface shared_resource_access_ctrl_if #(
    parameter int N = 8
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_err;
    logic [IDW-1:0] timeout_id;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout_err, timeout_id
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout_err, timeout_id
    );
endinterface

// File: rtl/shared_resource_access_ctrl.sv
// Round-robin lock arbiter: one owner holds the resource until release, then a one-cycle gap.
// Define SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN to build in the stuck-owner watchdog.
module shared_resource_access_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    shared_resource_access_ctrl_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int SW  = IDW + 1;
    localparam logic [N-1:0] ONE_HOT_LSB = N'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] rr_ptr;
    logic           busy;

    logic           win_valid;
    logic [IDW-1:0] win_id;
    logic [SW-1:0]  scan_sum;
    logic [IDW-1:0] next_ptr;
    logic           owner_rel;
    logic           expire;

    // Scan starts at rr_ptr and wraps, so the most recent owner is always last in line.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        win_valid = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, rr_ptr} + SW'(k);
            if (scan_sum >= SW'(N)) begin
                scan_sum = scan_sum - SW'(N);
            end
            if (!win_valid && bus.req[scan_sum[IDW-1:0]]) begin
                win_valid = 1'b1;
                win_id    = scan_sum[IDW-1:0];
            end
        end
    end

    assign next_ptr  = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
    assign owner_rel = bus.done[gnt_id] | ~bus.req[gnt_id];

`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_err;
    logic [IDW-1:0]   timeout_id;

    assign expire = (hold_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            rr_ptr <= '0;
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
`endif
        end else begin
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE, RELEASE: begin
                    if (win_valid) begin
                        state  <= OWNED;
                        gnt    <= ONE_HOT_LSB << win_id;
                        gnt_id <= win_id;
                        busy   <= 1'b1;
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                OWNED: begin
                    if (owner_rel || expire) begin
                        state  <= RELEASE;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
                        // A genuine release on the expiry cycle wins; no error is flagged.
                        if (!owner_rel) begin
                            timeout_err <= 1'b1;
                            timeout_id  <= gnt_id;
                        end
`endif
                    end
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
                    else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt;
    assign bus.gnt_id = gnt_id;
    assign bus.busy   = busy;
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
    assign bus.timeout_err = timeout_err;
    assign bus.timeout_id  = timeout_id;
`else
    assign bus.timeout_err = 1'b0;
    assign bus.timeout_id  = '0;
`endif
endmodule

// File: tb/tb_shared_resource_access_ctrl.sv
// Self-checking bench for shared_resource_access_ctrl against an ownership-level model.
// Builds with or without SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN; the watchdog scenario adapts.
module tb_shared_resource_access_ctrl;
    localparam int N       = 8;
    localparam int TIMEOUT = 16;
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shared_resource_access_ctrl_if #(.N(N)) bus ();

    shared_resource_access_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: who owns the resource, who is next in line, how long the owner has held it.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_last;
    int m_tid;
    bit m_err;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_last  = 0;
        m_tid   = 0;
        m_err   = 1'b0;
    endfunction

    function automatic int scan(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit rel;
        bit exp;
        int w;
        m_err = 1'b0;
        if (m_owner >= 0) begin
            rel = d[m_owner] || !r[m_owner];
            exp = WD && (m_held == TIMEOUT - 1);
            if (rel || exp) begin
                if (!rel) begin
                    m_err = 1'b1;
                    m_tid = m_owner;
                end
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else begin
            w = scan(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_held  = 0;
            end
        end
    endfunction

    // Advance one clock: the model sees the same inputs the DUT samples at the edge.
    task automatic cycle();
        @(posedge clk);
        model_step(bus.req, bus.done);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.gnt, bus.busy, bus.gnt_id, bus.timeout_err, bus.timeout_id} !== '0) begin
            errors++;
            $display("FAIL reset_state gnt=%h busy=%b gnt_id=%0d terr=%b tid=%0d expected all zero",
                     bus.gnt, bus.busy, bus.gnt_id, bus.timeout_err, bus.timeout_id);
        end
        rst_n   = 1'b1;
        bus.req = 8'h40;
        cycle();
        checks++;
        if (bus.gnt !== 8'h40 || bus.gnt_id !== 3'd6) begin
            errors++;
            $display("FAIL reset_pre_grant gnt=%h id=%0d expected gnt=40 id=6", bus.gnt, bus.gnt_id);
        end
        cycle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.gnt_id !== '0) begin
            errors++;
            $display("FAIL async_reset gnt=%h busy=%b id=%0d expected 0 without clock edge",
                     bus.gnt, bus.busy, bus.gnt_id);
        end
        model_reset();
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            cycle();
            checks++;
            if ({bus.gnt, bus.busy, bus.gnt_id, bus.timeout_err} !== '0) begin
                errors++;
                $display("FAIL post_reset_idle gnt=%h busy=%b id=%0d terr=%b expected all zero",
                         bus.gnt, bus.busy, bus.gnt_id, bus.timeout_err);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 8'h08;
        cycle();
        checks++;
        if (bus.gnt !== 8'h08 || bus.gnt_id !== 3'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant gnt=%h id=%0d busy=%b expected 08/3/1",
                     bus.gnt, bus.gnt_id, bus.busy);
        end
        repeat (3) begin
            cycle();
            checks++;
            if (bus.gnt !== 8'h08) begin
                errors++;
                $display("FAIL single_hold gnt=%h expected 08", bus.gnt);
            end
        end
        bus.done = 8'h08;
        cycle();
        bus.done = '0;
        bus.req  = '0;
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.gnt_id !== 3'd3) begin
            errors++;
            $display("FAIL single_release gnt=%h busy=%b id=%0d expected 00/0/3",
                     bus.gnt, bus.busy, bus.gnt_id);
        end
        cycle();
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle gnt=%h busy=%b expected 00/0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        bus.req = 8'hFF;
        for (int g = 0; g <= N; g++) begin
            want = '0;
            want[g % N] = 1'b1;
            cycle();
            checks++;
            if (bus.gnt !== want || bus.gnt_id !== 3'(g % N)) begin
                errors++;
                $display("FAIL fair_order round=%0d gnt=%h id=%0d expected gnt=%h", g, bus.gnt, bus.gnt_id, want);
            end
            cycle();
            bus.done = want;
            cycle();
            bus.done = '0;
            checks++;
            if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL fair_gap round=%0d gnt=%h busy=%b expected 00/0", g, bus.gnt, bus.busy);
            end
        end
        bus.req = '0;
        cycle();
    endtask

    task automatic test_req_drop();
        logic [N-1:0] others;
        logic [N-1:0] want;
        int w;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            bus.req = 8'h20;
            cycle();
            others = 8'($urandom) & 8'hDF;
            if (it % 3 == 0) others = '0;
            bus.req  = others;
            bus.done = 8'h04;
            cycle();
            bus.done = '0;
            checks++;
            if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL drop_release iter=%0d gnt=%h busy=%b expected 00/0", it, bus.gnt, bus.busy);
            end
            cycle();
            w    = scan(others, 6);
            want = '0;
            if (w >= 0) want[w] = 1'b1;
            checks++;
            if (bus.gnt !== want) begin
                errors++;
                $display("FAIL drop_next_winner iter=%0d req=%h gnt=%h expected %h", it, others, bus.gnt, want);
            end
        end
        bus.req = '0;
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) bus.req[b] = ~bus.req[b];
            end
            bus.done = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cycle();
            checks++;
            if (bus.gnt !== model_gnt() || bus.busy !== (m_owner >= 0) || bus.gnt_id !== 3'(m_last) ||
                bus.timeout_err !== m_err || bus.timeout_id !== 3'(m_tid) || !$onehot0(bus.gnt)) begin
                errors++;
                $display("FAIL random cyc=%0d gnt=%h busy=%b id=%0d terr=%b tid=%0d expected gnt=%h busy=%b id=%0d terr=%b tid=%0d",
                         c, bus.gnt, bus.busy, bus.gnt_id, bus.timeout_err, bus.timeout_id,
                         model_gnt(), (m_owner >= 0), m_last, m_err, m_tid);
            end
        end
        bus.req  = '0;
        bus.done = '0;
        cycle();
    endtask

    task automatic test_watchdog();
        int cnt;
        do_reset();
        bus.req = 8'h02;
        cycle();
`ifdef SHARED_RESOURCE_ACCESS_CTRL_TIMEOUT_EN
        cnt = 0;
        while (bus.gnt === 8'h02 && cnt < 100) begin
            cnt++;
            cycle();
        end
        checks++;
        if (cnt != TIMEOUT) begin
            errors++;
            $display("FAIL wd_hold_len cycles=%0d expected %0d", cnt, TIMEOUT);
        end
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.timeout_id !== 3'd1 || bus.gnt !== '0) begin
            errors++;
            $display("FAIL wd_error terr=%b tid=%0d gnt=%h expected 1/1/00",
                     bus.timeout_err, bus.timeout_id, bus.gnt);
        end
        cycle();
        checks++;
        if (bus.gnt !== 8'h02 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_regrant gnt=%h terr=%b expected 02/0", bus.gnt, bus.timeout_err);
        end
        cnt = 0;
        while (m_held != TIMEOUT - 1 && cnt < 100) begin
            cnt++;
            cycle();
        end
        bus.req = '0;
        cycle();
        checks++;
        if (bus.gnt !== '0 || bus.timeout_err !== 1'b0 || bus.timeout_id !== 3'd1) begin
            errors++;
            $display("FAIL wd_coincide gnt=%h terr=%b tid=%0d expected 00/0/1",
                     bus.gnt, bus.timeout_err, bus.timeout_id);
        end
`else
        cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.gnt !== 8'h02 || bus.timeout_err !== 1'b0) cnt++;
            cycle();
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL nowd_unbounded bad_cycles=%0d expected 0 (gnt held 02, terr 0)", cnt);
        end
`endif
        bus.req = '0;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_req_drop();
        test_random();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
